// File: rtl/add_result_collector.sv
// Result collector behind the two-phase 64-bit adder: tracks the LOAD/SHIFT/SUM
// schedule, captures sum/carry/overflow with a sequence tag and queues results.
module add_result_collector #(
    parameter int N     = 64,
    parameter int DEPTH = 4,
    parameter int TAGW  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     slot_en,
    input  logic                     op_a_msb,
    input  logic                     op_b_msb,
    input  logic [N-1:0]             sum,
    input  logic                     cout,
    output logic [1:0]               phase,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_sum,
    output logic                     out_cout,
    output logic                     out_ovf,
    output logic [TAGW-1:0]          out_tag,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        PH_LOAD  = 2'd0,
        PH_SHIFT = 2'd1,
        PH_SUM   = 2'd2,
        PH_BAD   = 2'd3
    } phase_t;

    phase_t state, state_nxt;
    logic   capture;

    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [TAGW-1:0] tag_ctr;

    logic [N-1:0]    mem_sum  [DEPTH];
    logic            mem_cout [DEPTH];
    logic            mem_ovf  [DEPTH];
    logic [TAGW-1:0] mem_tag  [DEPTH];

    logic cap_ovf;
    logic pop, push, drop, full;

    // Phase machine mirrors the adder's schedule; shares the adder's reset net.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= PH_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = PH_LOAD;
        capture   = 1'b0;
        case (state)
            PH_LOAD:  state_nxt = PH_SHIFT;
            PH_SHIFT: state_nxt = PH_SUM;
            PH_SUM: begin
                state_nxt = PH_LOAD;
                capture   = slot_en;
            end
            default:  state_nxt = PH_LOAD;
        endcase
    end

    assign phase = state;

    assign cap_ovf = (op_a_msb == op_b_msb) && (sum[N-1] != op_a_msb);

    assign full = (count == FULL_COUNT);
    assign pop  = out_valid && out_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push = capture && (!full || pop);
    assign drop = capture && !push;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tag_ctr  <= '0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (capture) begin
                tag_ctr <= tag_ctr + 1'b1;
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_sum[i]  <= '0;
                mem_cout[i] <= 1'b0;
                mem_ovf[i]  <= 1'b0;
                mem_tag[i]  <= '0;
            end
        end else if (push) begin
            mem_sum[wr_ptr]  <= sum;
            mem_cout[wr_ptr] <= cout;
            mem_ovf[wr_ptr]  <= cap_ovf;
            mem_tag[wr_ptr]  <= tag_ctr;
        end
    end

    assign out_valid  = (count != '0);
    assign fifo_count = count;
    assign out_sum    = mem_sum[rd_ptr];
    assign out_cout   = mem_cout[rd_ptr];
    assign out_ovf    = mem_ovf[rd_ptr];
    assign out_tag    = mem_tag[rd_ptr];

endmodule

// File: tb/tb_add_result_collector.sv
// Scoreboard bench for add_result_collector: randomized slots against a queue model.
module tb_add_result_collector;

    localparam int N     = 64;
    localparam int DEPTH = 4;
    localparam int TAGW  = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           slot_en = 1'b0;
    logic           op_a_msb = 1'b0;
    logic           op_b_msb = 1'b0;
    logic [N-1:0]   sum = '0;
    logic           cout = 1'b0;
    logic [1:0]     phase;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [N-1:0]   out_sum;
    logic           out_cout;
    logic           out_ovf;
    logic [TAGW-1:0] out_tag;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [15:0]    drop_cnt;

    add_result_collector #(.N(N), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .slot_en(slot_en), .op_a_msb(op_a_msb),
        .op_b_msb(op_b_msb), .sum(sum), .cout(cout), .phase(phase),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf), .out_tag(out_tag),
        .fifo_count(fifo_count), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        o;
        logic [7:0]  t;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   model_drops = 0;
    int   model_tag = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycles since reset release; phase is this count modulo 3.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("phase", 64'(phase), 64'(cyc % 3));
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            chk("fifo_count", 64'(fifo_count), 64'(exp_q.size()));
            chk("drop_cnt", 64'(drop_cnt), 64'(model_drops > 65535 ? 65535 : model_drops));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_empty: got valid pop expected empty queue at %0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_sum", out_sum, mon_e.s);
                    chk("out_cout", 64'(out_cout), 64'(mon_e.c));
                    chk("out_ovf", 64'(out_ovf), 64'(mon_e.o));
                    chk("out_tag", 64'(out_tag), 64'(mon_e.t));
                end
            end
        end
    end

    function automatic logic [63:0] rand_op();
        logic [63:0] v;
        case ($urandom % 6)
            0:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            1:       v = 64'h8000_0000_0000_0000;
            2:       v = '1;
            3:       v = '0;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // One LOAD/SHIFT/SUM slot; must be entered while the DUT is in LOAD.
    // rmode: 0 ready low, 1 ready high, 2 random per cycle, 3 high only in SUM.
    task automatic run_slot(input logic en, input logic [63:0] a, input logic [63:0] b,
                            input int rmode);
        logic [64:0] u;
        logic [64:0] sx;
        exp_t e;
        u  = {1'b0, a} + {1'b0, b};
        sx = {a[63], a} + {b[63], b};
        for (int ph = 0; ph < 3; ph++) begin
            op_a_msb = a[63];
            op_b_msb = b[63];
            if (ph == 2) begin
                sum     = u[63:0];
                cout    = u[64];
                slot_en = en;
            end else begin
                sum     = {$urandom, $urandom};
                cout    = 1'($urandom);
                slot_en = en ? 1'($urandom) : 1'b1;
            end
            case (rmode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                2:       out_ready = 1'($urandom);
                default: out_ready = (ph == 2);
            endcase
            @(posedge clk);
            #1;
        end
        if (en) begin
            e.s = u[63:0];
            e.c = u[64];
            e.o = sx[64] ^ sx[63];
            e.t = 8'(model_tag);
            model_tag++;
            if (exp_q.size() < DEPTH) exp_q.push_back(e);
            else                      model_drops++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        slot_en   = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 3 && (cyc % 3) != 0; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        mon_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_phase", 64'(phase), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_sum", out_sum, 64'd0);
        chk("rst_cout", 64'(out_cout), 64'd0);
        chk("rst_ovf", 64'(out_ovf), 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        exp_q.delete();
        model_drops = 0;
        model_tag   = 0;
        slot_en     = 1'b0;
        out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 mon_en = 1'b1;
    endtask

    initial begin
        apply_reset();

        run_slot(1'b1, 64'd5, 64'd7, 1);
        chk("basic_valid", 64'(out_valid), 64'd1);
        chk("basic_sum", out_sum, 64'd12);
        chk("basic_cout", 64'(out_cout), 64'd0);
        chk("basic_ovf", 64'(out_ovf), 64'd0);
        chk("basic_tag", 64'(out_tag), 64'd0);

        run_slot(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1);
        chk("ovf_sum", out_sum, 64'h8000_0000_0000_0000);
        chk("ovf_flag", 64'(out_ovf), 64'd1);
        chk("ovf_cout", 64'(out_cout), 64'd0);

        run_slot(1'b1, '1, '1, 1);
        chk("neg_sum", out_sum, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("neg_cout", 64'(out_cout), 64'd1);
        chk("neg_ovf", 64'(out_ovf), 64'd0);
        drain();

        apply_reset();
        repeat (6) run_slot(1'b1, rand_op(), rand_op(), 0);
        chk("bp_count", 64'(fifo_count), 64'd4);
        chk("bp_drop", 64'(drop_cnt), 64'd2);
        drain();

        repeat (4) run_slot(1'b1, rand_op(), rand_op(), 0);
        run_slot(1'b1, rand_op(), rand_op(), 3);
        chk("fullpop_count", 64'(fifo_count), 64'd4);
        chk("fullpop_drop", 64'(drop_cnt), 64'd2);
        drain();

        repeat (3) run_slot(1'b0, rand_op(), rand_op(), 1);
        chk("dis_count", 64'(fifo_count), 64'd0);
        chk("dis_drop", 64'(drop_cnt), 64'd2);
        run_slot(1'b1, rand_op(), rand_op(), 1);
        chk("dis_next_tag", 64'(out_tag), 64'd11);
        drain();

        repeat (150) run_slot(1'($urandom % 4 != 0), rand_op(), rand_op(), 2);
        drain();

        repeat (3) run_slot(1'b1, rand_op(), rand_op(), 0);
        @(posedge clk);
        #1;
        chk("mid_phase_shift", 64'(phase), 64'd1);
        apply_reset();
        run_slot(1'b1, 64'd3, 64'd4, 1);
        chk("post_rst_tag", 64'(out_tag), 64'd0);
        chk("post_rst_sum", out_sum, 64'd7);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/add_result_collector.md
# add_result_collector

Downstream stage of the two-phase 64-bit adder. Tracks the adder's three-cycle LOAD/SHIFT/SUM schedule with its own phase counter, reset alongside the adder. In the SUM phase it captures the adder's `sum`/`cout`, computes signed overflow and a sequence tag, and pushes the result into a small FIFO. Results leave through a valid/ready interface toward the register-writeback logic.

## Interface

Parameters:
- `N`, default 64: operand and sum width. Must be even.
- `DEPTH`, default 4: result FIFO entries. Power of two, at least 2.
- `TAGW`, default 8: sequence tag width.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. Asynchronous, active-low.
- `slot_en`, in, 1: upstream marks the current three-cycle slot as carrying a real operation. Sampled in phase SUM only.
- `op_a_msb`, in, 1: sign bit of `inp1`, as fed to the adder.
- `op_b_msb`, in, 1: sign bit of `inp2`, as fed to the adder.
- `sum`, in, N: adder sum output.
- `cout`, in, 1: adder carry output.
- `phase`, out, 2: current phase. 0 = LOAD, 1 = SHIFT, 2 = SUM.
- `out_valid`, out, 1: FIFO head valid.
- `out_ready`, in, 1: consumer accepts the head.
- `out_sum`, out, N: head sum.
- `out_cout`, out, 1: head carry.
- `out_ovf`, out, 1: head signed overflow.
- `out_tag`, out, TAGW: head sequence tag.
- `fifo_count`, out, log2(DEPTH)+1: current occupancy.
- `drop_cnt`, out, 16: results lost because the FIFO was full. Saturates at 0xFFFF.

## Operation

**Phase counter**
- Sequence is LOAD → SHIFT → SUM → LOAD, free-running with no stall.
- Value 3 is illegal; if it ever occurs, the next state is LOAD.
- `rst` must be the same net as the adder's reset, so both phase machines stay aligned.

**Capture**
- A capture happens at the rising edge that ends a SUM cycle, when `slot_en` is 1.
- It samples `sum`, `cout`, `op_a_msb` and `op_b_msb` as held during that SUM cycle.
- Upstream holds `inp1`/`inp2` stable over the whole LOAD–SUM slot.
- Overflow: `ovf = (op_a_msb == op_b_msb) && (sum[N-1] != op_a_msb)`.
- Tag: the internal `tag_ctr` value, incremented on every capture whether accepted or dropped. Wraps modulo 2^TAGW.
- `slot_en` in LOAD or SHIFT is ignored.

**FIFO**
- Circular buffer with write pointer, read pointer and count.
- A push is accepted when `count < DEPTH`, or when `count == DEPTH` and a pop occurs on the same edge.
- Otherwise the push is dropped, `drop_cnt` increments (saturating), and the tag is still consumed.
- A pop occurs when `out_valid && out_ready`.
- Push and pop on the same edge leave count unchanged and advance both pointers.
- Pointers wrap modulo DEPTH.
- `out_*` are driven from the registered head entry. No combinational path from `sum` to `out_*`.
- `out_sum`, `out_cout`, `out_ovf` and `out_tag` are don't-care while `out_valid` is 0.

**Reset** (asynchronous, any time, including mid-slot)
- `phase` = 0, `out_valid` = 0, `fifo_count` = 0, `drop_cnt` = 0, `tag_ctr` = 0.
- `out_sum`, `out_cout`, `out_ovf` and `out_tag` = 0; storage is cleared.
- After release, the first SUM phase is the third clock edge after deassertion.

## Timing

- The phase advances on every rising edge. Captures are possible at most once every 3 cycles.
- Capture to `out_valid`: `out_valid` is high in the cycle after the capture edge when the FIFO was empty (1-cycle latency).
- `out_ready` is sampled on the rising edge. The head updates in the cycle after a pop.
- Upstream must not change operands during a slot. If it does, the captured value is undefined but the FIFO stays consistent.
- Full FIFO with `out_ready` held at 1 sustains one result per 3 cycles with no drops.
- `drop_cnt` increments on the capture edge of a dropped result.

## Test plan

- **Basic add:** reset, then `slot_en`=1 in slot 0 with `inp1`=5, `inp2`=7. Required: `out_valid`=1 one cycle after the SUM edge; `out_sum`=12, `cout`=0, `ovf`=0, `tag`=0.
- **Signed overflow:** `inp1`=0x7FFF_FFFF_FFFF_FFFF, `inp2`=1. Required: `out_sum`=0x8000_0000_0000_0000, `ovf`=1, `cout`=0. Then `inp1`=−1, `inp2`=−1: `sum`=−2, `cout`=1, `ovf`=0.
- **Backpressure and drop:** `out_ready`=0 with 6 consecutive enabled slots at DEPTH=4. Required: `fifo_count`=4, `drop_cnt`=2. Then `out_ready`=1: 4 pops in order with tags 0, 1, 2, 3.
- **Full with simultaneous pop:** FIFO full, `out_ready`=1 on the capture edge. Required: push accepted, `fifo_count` stays 4, `drop_cnt` unchanged.
- **Disabled slots:** `slot_en`=0 in SUM while high in LOAD/SHIFT. Required: no push, tag not incremented, `drop_cnt` unchanged.
- **Reset mid-operation:** assert `rst` in SHIFT with 3 entries queued. Required: all outputs 0 immediately. After release, `phase` sequences 0, 1, 2 and the first captured tag is 0.
